// File: rtl/traffic_light_monitor.sv
// Passive checker for red/yellow/green lamp lines: decodes phases, times them and flags order, exclusivity and duration errors.
// Defining MON_ERR_LOG_EN adds a first-error snapshot on first_err; otherwise first_err is tied to 0.
module traffic_light_monitor #(
    parameter int TICK_DIV   = 10,
    parameter int RED_SEC    = 19,
    parameter int GREEN_SEC  = 16,
    parameter int YELLOW_SEC = 4,
    parameter int TOL_SEC    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        red_light,
    input  logic        yellow_light,
    input  logic        green_light,
    input  logic        clr_err,
    output logic [1:0]  phase,
    output logic [5:0]  phase_secs,
    output logic        err_seq,
    output logic        err_multi,
    output logic        err_dark,
    output logic        err_timing,
    output logic        fault,
    output logic [15:0] cycle_cnt,
    output logic [3:0]  first_err
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    // Singles share the low two bits with the phase output; DARK and MULTI both map to 11.
    localparam logic [2:0] PH_RED    = 3'd0;
    localparam logic [2:0] PH_YELLOW = 3'd1;
    localparam logic [2:0] PH_GREEN  = 3'd2;
    localparam logic [2:0] PH_DARK   = 3'd3;
    localparam logic [2:0] PH_MULTI  = 3'd4;

    function automatic int exp_secs(input logic [2:0] ph);
        case (ph)
            PH_RED:    return RED_SEC;
            PH_YELLOW: return YELLOW_SEC;
            PH_GREEN:  return GREEN_SEC;
            default:   return 0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] from_ph, input logic [2:0] to_ph);
        return (from_ph == PH_RED    && to_ph == PH_GREEN)  ||
               (from_ph == PH_GREEN  && to_ph == PH_YELLOW) ||
               (from_ph == PH_YELLOW && to_ph == PH_RED);
    endfunction

    logic [2:0]    r_s1;
    logic [2:0]    r_prev_ph;
    logic [1:0]    r_state;
    logic [PW-1:0] r_pre;
    logic [5:0]    r_secs;
    logic          r_chk;
    logic          r_ovr;
    logic          r_err_seq;
    logic          r_err_multi;
    logic          r_err_dark;
    logic          r_err_timing;
    logic [15:0]   r_cycle_cnt;

    logic [2:0]    w_ph;
    logic          w_single;
    logic          w_change;
    logic          w_hold;
    logic          w_tick;
    logic [5:0]    w_secs_inc;
    int            w_secs_now;
    int            w_prev_exp;
    int            w_cur_exp;
    logic [1:0]    w_state_nxt;
    logic          w_chk_nxt;
    logic          w_ovr_nxt;
    logic          w_set_seq;
    logic          w_set_multi;
    logic          w_set_dark;
    logic          w_set_tim;
    logic          w_cnt_inc;

    always_comb begin
        unique case (r_s1)
            3'b100:  w_ph = PH_RED;
            3'b010:  w_ph = PH_YELLOW;
            3'b001:  w_ph = PH_GREEN;
            3'b000:  w_ph = PH_DARK;
            default: w_ph = PH_MULTI;
        endcase
    end

    assign w_single   = (w_ph <= PH_GREEN);
    assign w_change   = (w_ph != r_prev_ph);
    assign w_hold     = !en || (r_state == ST_IDLE);
    assign w_tick     = !w_hold && !w_change && (r_pre == PRE_MAX);
    assign w_secs_inc = (r_secs == 6'd63) ? 6'd63 : r_secs + 6'd1;
    assign w_secs_now = int'(r_secs);
    assign w_prev_exp = exp_secs(r_prev_ph);
    assign w_cur_exp  = exp_secs(w_ph);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_chk_nxt   = r_chk;
        w_ovr_nxt   = r_ovr;
        w_set_seq   = 1'b0;
        w_set_multi = 1'b0;
        w_set_dark  = 1'b0;
        w_set_tim   = 1'b0;
        w_cnt_inc   = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (w_change && w_ph == PH_MULTI) w_set_multi = 1'b1;
                    // The phase that brings us into TRACK may be partial, so its length is never judged.
                    if (w_single) begin
                        w_state_nxt = ST_TRACK;
                        w_chk_nxt   = 1'b0;
                        w_ovr_nxt   = 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (w_change) begin
                        if (w_ph == PH_DARK) begin
                            w_set_dark  = 1'b1;
                            w_state_nxt = ST_SYNC;
                        end else if (w_ph == PH_MULTI) begin
                            w_set_multi = 1'b1;
                            w_state_nxt = ST_SYNC;
                        end else begin
                            if (!is_legal(r_prev_ph, w_ph)) w_set_seq = 1'b1;
                            else if (r_prev_ph == PH_YELLOW) w_cnt_inc = 1'b1;
                            if (r_chk && !r_ovr &&
                                (w_secs_now < w_prev_exp - TOL_SEC || w_secs_now > w_prev_exp + TOL_SEC))
                                w_set_tim = 1'b1;
                            w_chk_nxt = 1'b1;
                            w_ovr_nxt = 1'b0;
                        end
                    end else if (r_chk && !r_ovr && w_tick && int'(w_secs_inc) > w_cur_exp + TOL_SEC) begin
                        w_set_tim = 1'b1;
                        w_ovr_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1         <= '0;
            r_prev_ph    <= '0;
            r_state      <= ST_IDLE;
            r_pre        <= '0;
            r_secs       <= '0;
            r_chk        <= 1'b0;
            r_ovr        <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_multi  <= 1'b0;
            r_err_dark   <= 1'b0;
            r_err_timing <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            r_s1      <= {red_light, yellow_light, green_light};
            r_prev_ph <= w_ph;
            r_state   <= w_state_nxt;
            r_chk     <= w_chk_nxt;
            r_ovr     <= w_ovr_nxt;

            if (w_hold || w_change || r_pre == PRE_MAX) r_pre <= '0;
            else                                        r_pre <= r_pre + 1'b1;

            if (w_hold || w_change) r_secs <= '0;
            else if (w_tick)        r_secs <= w_secs_inc;

            // A new error in the same cycle as clr_err wins.
            r_err_seq    <= (r_err_seq    & ~clr_err) | w_set_seq;
            r_err_multi  <= (r_err_multi  & ~clr_err) | w_set_multi;
            r_err_dark   <= (r_err_dark   & ~clr_err) | w_set_dark;
            r_err_timing <= (r_err_timing & ~clr_err) | w_set_tim;

            if (w_cnt_inc) r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign phase      = w_ph[2] ? 2'b11 : w_ph[1:0];
    assign phase_secs = r_secs;
    assign err_seq    = r_err_seq;
    assign err_multi  = r_err_multi;
    assign err_dark   = r_err_dark;
    assign err_timing = r_err_timing;
    assign fault      = r_err_seq | r_err_multi | r_err_dark | r_err_timing;
    assign cycle_cnt  = r_cycle_cnt;

`ifdef MON_ERR_LOG_EN
    logic       r_logged;
    logic [3:0] r_first_err;
    logic       w_any_err;
    logic [1:0] w_err_code;

    assign w_any_err = w_set_seq | w_set_multi | w_set_dark | w_set_tim;

    always_comb begin
        if (w_set_multi)     w_err_code = 2'b01;
        else if (w_set_dark) w_err_code = 2'b10;
        else if (w_set_seq)  w_err_code = 2'b00;
        else                 w_err_code = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_logged    <= 1'b0;
            r_first_err <= '0;
        end else if (w_any_err && (clr_err || !r_logged)) begin
            r_logged    <= 1'b1;
            r_first_err <= {w_err_code, phase};
        end else if (clr_err) begin
            r_logged    <= 1'b0;
            r_first_err <= '0;
        end
    end

    assign first_err = r_first_err;
`else
    assign first_err = '0;
`endif

endmodule
